// File: rtl/run_sequencer_pkg.sv
// rtl/run_sequencer_pkg.sv - shared mode and state codes for the run sequencer
// Purpose: mode-select codes as seen on mode_in, FSM state codes (also the
//          state_o LED encoding), and the mode-to-state mapping.
// Ports:   none (package).
package run_seq_pkg;

  localparam logic [1:0] MODE_STOP = 2'b00;
  localparam logic [1:0] MODE_RUN  = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;
  localparam logic [1:0] MODE_DIV  = 2'b11;

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_STOP  = 3'd1,
    S_RUN   = 3'd2,
    S_STEP  = 3'd3,
    S_DIV   = 3'd4
  } state_t;

  function automatic state_t mode_state(input logic [1:0] mode);
    case (mode)
      MODE_STOP: mode_state = S_STOP;
      MODE_RUN:  mode_state = S_RUN;
      MODE_STEP: mode_state = S_STEP;
      MODE_DIV:  mode_state = S_DIV;
    endcase
  endfunction

endpackage

// File: rtl/run_sequencer_if.sv
// rtl/run_sequencer_if.sv - control/status bundle between pins and the run sequencer
// Purpose: groups the control inputs and core-facing outputs of run_sequencer.
// Ports (signals):
//   mode_in    2      async mode select (00 STOP, 01 RUN, 10 STEP, 11 DIV)
//   step_in    1      async, bouncy step pushbutton, active high
//   div_sel    4      DIV mode: core runs 1 cycle in 2^div_sel
//   core_reset 1      active-high reset to the core
//   core_run   1      run enable to the core
//   state_o    3      FSM state code for debug LEDs
//   run_count  CNT_W  cycles in which core_run was 1, wrapping
// Modports: master drives the controls, slave is the sequencer.
interface run_sequencer_if #(
  parameter int CNT_W = 16
);
  logic [1:0]       mode_in;
  logic             step_in;
  logic [3:0]       div_sel;
  logic             core_reset;
  logic             core_run;
  logic [2:0]       state_o;
  logic [CNT_W-1:0] run_count;

  modport master (
    output mode_in, step_in, div_sel,
    input  core_reset, core_run, state_o, run_count
  );

  modport slave (
    input  mode_in, step_in, div_sel,
    output core_reset, core_run, state_o, run_count
  );
endinterface

// File: rtl/run_sequencer_step_debouncer.sv
// rtl/run_sequencer_step_debouncer.sv - synchronise, debounce and edge-detect the step button
// Purpose: 2-FF synchroniser, stability counter and one-cycle rising-edge pulse.
// Ports:
//   clk      in   clock
//   rst_n    in   synchronous active-low reset
//   step_in  in   raw asynchronous pushbutton
//   rise     out  one-cycle pulse on the edge the debounced level goes 0->1
module step_debouncer #(
  parameter int DEBOUNCE = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic step_in,
  output logic rise
);
  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // cnt holds how many consecutive edges the synchronised input has
  // disagreed with the debounced level; the level flips on the DEBOUNCE-th.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
    end else begin
      sync1 <= step_in;
      sync2 <= sync1;
      rise  <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE - 1)) begin
        cnt   <= '0;
        level <= sync2;
        rise  <= sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/run_sequencer.sv
// rtl/run_sequencer.sv - reset stretcher and run gating for the generated core
// Purpose: stretches core_reset after rst_n release, then gates core_run in
//          STOP / RUN / debounced single-STEP / divided-DIV modes and counts
//          the cycles in which the core ran.
// Ports:
//   clk    in   clock
//   rst_n  in   synchronous active-low reset
//   bus    run_sequencer_if.slave (mode_in, step_in, div_sel in;
//          core_reset, core_run, state_o, run_count out)
module run_sequencer
  import run_seq_pkg::*;
#(
  parameter int RST_CYCLES = 16,
  parameter int DEBOUNCE   = 1024,
  parameter int CNT_W      = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  run_sequencer_if.slave bus
);
  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  state_t           state;
  logic             core_reset_q;
  logic             core_run_q;
  logic [CNT_W-1:0] run_count_q;
  logic [RC_W-1:0]  rst_cnt;
  logic [15:0]      presc;
  logic [15:0]      presc_max;
  logic [1:0]       mode_s1;
  logic [1:0]       mode_s2;
  logic [3:0]       div_q;
  logic             step_rise;
  state_t           target;

  step_debouncer #(
    .DEBOUNCE(DEBOUNCE)
  ) u_step (
    .clk     (clk),
    .rst_n   (rst_n),
    .step_in (bus.step_in),
    .rise    (step_rise)
  );

  assign target    = mode_state(mode_s2);
  assign presc_max = (16'd1 << bus.div_sel) - 16'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_RESET;
      core_reset_q <= 1'b1;
      core_run_q   <= 1'b0;
      run_count_q  <= '0;
      rst_cnt      <= '0;
      presc        <= '0;
      mode_s1      <= MODE_STOP;
      mode_s2      <= MODE_STOP;
      div_q        <= '0;
    end else begin
      mode_s1 <= bus.mode_in;
      mode_s2 <= mode_s1;
      div_q   <= bus.div_sel;
      if (core_run_q) begin
        run_count_q <= run_count_q + CNT_W'(1);
      end

      case (state)
        S_RESET: begin
          core_run_q <= 1'b0;
          if (rst_cnt == RC_W'(RST_CYCLES - 1)) begin
            // Last stretch edge: release the core straight into the selected mode.
            state        <= target;
            core_reset_q <= 1'b0;
            rst_cnt      <= '0;
            presc        <= '0;
          end else begin
            core_reset_q <= 1'b1;
            rst_cnt      <= rst_cnt + RC_W'(1);
          end
        end

        S_STOP, S_RUN, S_STEP, S_DIV: begin
          core_reset_q <= 1'b0;
          if (state != target) begin
            // Transition cycle: the core is held and a pending step pulse is dropped.
            state      <= target;
            core_run_q <= 1'b0;
            presc      <= '0;
          end else begin
            case (state)
              S_RUN:  core_run_q <= 1'b1;
              S_STEP: core_run_q <= step_rise;
              S_DIV: begin
                if (bus.div_sel != div_q) begin
                  presc      <= '0;
                  core_run_q <= 1'b0;
                end else begin
                  core_run_q <= (presc == presc_max);
                  presc      <= (presc == presc_max) ? 16'd0 : presc + 16'd1;
                end
              end
              default: core_run_q <= 1'b0;
            endcase
          end
        end

        default: begin
          state        <= S_RESET;
          core_reset_q <= 1'b1;
          core_run_q   <= 1'b0;
          rst_cnt      <= '0;
        end
      endcase
    end
  end

  assign bus.core_reset = core_reset_q;
  assign bus.core_run   = core_run_q;
  assign bus.state_o    = state;
  assign bus.run_count  = run_count_q;
endmodule

// File: tb/tb_run_sequencer.sv
// tb/tb_run_sequencer.sv - randomized, model-checked bench for run_sequencer
module tb_run_sequencer;
  localparam int RC = 4;
  localparam int DB = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] mode_in;
  logic       step_in;
  logic [3:0] div_sel;

  int tests = 0;
  int fails = 0;

  run_sequencer_if #(.CNT_W(16)) bus_w ();
  run_sequencer_if #(.CNT_W(4))  bus_n ();

  assign bus_w.mode_in = mode_in;
  assign bus_w.step_in = step_in;
  assign bus_w.div_sel = div_sel;
  assign bus_n.mode_in = mode_in;
  assign bus_n.step_in = step_in;
  assign bus_n.div_sel = div_sel;

  run_sequencer #(.RST_CYCLES(RC), .DEBOUNCE(DB), .CNT_W(16)) dut_w (
    .clk(clk), .rst_n(rst_n), .bus(bus_w.slave)
  );
  run_sequencer #(.RST_CYCLES(RC), .DEBOUNCE(DB), .CNT_W(4)) dut_n (
    .clk(clk), .rst_n(rst_n), .bus(bus_n.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Behavioural model: outputs expected after each edge.
  bit          valid = 1'b0;
  bit          m_reset;
  bit          m_run;
  bit          m_lvl;
  bit          m_pulse;
  int          m_rel;
  int          m_k;
  int          m_cnt;
  logic [1:0]  m_mode;
  logic [1:0]  ms1, ms2;
  logic        ss1, ss2;
  logic [DB-1:0] m_win;
  logic [3:0]  m_divprev;

  always @(posedge clk) begin : model
    logic [1:0] ms;
    logic       ss;
    bit         nr;
    bit         np;
    int         n;
    if (!rst_n) begin
      valid = 1'b1;
      m_reset = 1'b1; m_run = 1'b0; m_lvl = 1'b0; m_pulse = 1'b0;
      m_rel = 0; m_k = 0; m_cnt = 0; m_mode = 2'd0;
      ms1 = 2'd0; ms2 = 2'd0; ss1 = 1'b0; ss2 = 1'b0;
      m_win = '0; m_divprev = 4'd0;
    end else if (valid) begin
      ms = ms2;
      ss = ss2;
      n  = 1 << div_sel;
      m_cnt = m_cnt + (m_run ? 1 : 0);
      // debounced level follows the last DB synchronised samples when they all agree
      m_win = {m_win[DB-2:0], ss};
      np = 1'b0;
      if (!m_lvl && m_win == '1) begin m_lvl = 1'b1; np = 1'b1; end
      else if (m_lvl && m_win == '0) m_lvl = 1'b0;
      nr = 1'b0;
      if (m_reset) begin
        m_rel++;
        if (m_rel == RC) begin m_reset = 1'b0; m_mode = ms; m_k = 0; end
      end else if (ms != m_mode) begin
        m_mode = ms; m_k = 0;
      end else begin
        case (m_mode)
          2'd1: nr = 1'b1;
          2'd2: nr = m_pulse;
          2'd3: begin
            if (div_sel != m_divprev) m_k = 0;
            else begin nr = ((m_k % n) == n - 1); m_k++; end
          end
          default: nr = 1'b0;
        endcase
      end
      m_run = nr;
      m_pulse = np;
      m_divprev = div_sel;
      ms2 = ms1; ms1 = mode_in;
      ss2 = ss1; ss1 = step_in;
    end
  end

  always @(negedge clk) begin : compare
    logic [2:0] es;
    if (valid) begin
      es = m_reset ? 3'd0 : 3'({1'b0, m_mode}) + 3'd1;
      check("core_reset", bus_w.core_reset, m_reset);
      check("core_run", bus_w.core_run, m_run);
      check("state_o", bus_w.state_o, es);
      check("run_count", bus_w.run_count, m_cnt & 32'hFFFF);
      check("run_count4", bus_n.run_count, m_cnt & 32'hF);
      check("core_run4", bus_n.core_run, m_run);
      check("run_while_reset", bus_w.core_run & bus_w.core_reset, 0);
    end
  end

  initial begin
    int pulses;
    int first;
    int r;
    bit hit;
    rst_n = 1'b0; mode_in = 2'd1; step_in = 1'b0; div_sel = 4'd0;
    repeat (3) tick();
    check("reset_core_reset", bus_w.core_reset, 1);
    check("reset_run_count", bus_w.run_count, 0);
    rst_n = 1'b1;
    // reset stretch: 4 edges, then RUN with one transition cycle
    for (int e = 1; e <= 3; e++) begin
      tick();
      check("stretch_reset", bus_w.core_reset, 1);
      check("stretch_run", bus_w.core_run, 0);
    end
    tick();
    check("exit_reset", bus_w.core_reset, 0);
    check("exit_run", bus_w.core_run, 0);
    check("exit_state", bus_w.state_o, 2);
    tick();
    check("first_run", bus_w.core_run, 1);
    check("first_count", bus_w.run_count, 0);
    repeat (18) tick();
    check("count18", bus_w.run_count, 18);
    check("wrap4", bus_n.run_count, 2);

    // RUN -> STOP
    mode_in = 2'd0;
    repeat (2) tick();
    check("stop_lag", bus_w.core_run, 1);
    tick();
    check("stop_run", bus_w.core_run, 0);
    repeat (10) tick();

    // STEP with bouncy press
    mode_in = 2'd2;
    repeat (4) tick();
    pulses = 0; first = -1;
    for (int i = 0; i < 4; i++) begin
      step_in = ~i[0];
      repeat (2) begin tick(); if (bus_w.core_run) pulses++; end
    end
    step_in = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus_w.core_run) begin pulses++; if (first < 0) first = i; end
    end
    check("step_pulses1", pulses, 1);
    check("step_latency", (first >= DB) ? 1 : 0, 1);
    step_in = 1'b0;
    repeat (20) begin tick(); if (bus_w.core_run) pulses++; end
    step_in = 1'b1;
    repeat (30) begin tick(); if (bus_w.core_run) pulses++; end
    check("step_pulses2", pulses, 2);
    step_in = 1'b0;

    // DIV by 4, then by 1
    mode_in = 2'd3; div_sel = 4'd2;
    pulses = 0;
    repeat (40) begin tick(); if (bus_w.core_run) pulses++; end
    check("div4_pulses", (pulses >= 9 && pulses <= 11) ? 1 : 0, 1);
    div_sel = 4'd0;
    tick();
    check("div_change_run", bus_w.core_run, 0);
    pulses = 0;
    repeat (8) begin tick(); if (bus_w.core_run) pulses++; end
    check("div1_pulses", pulses, 8);

    // Reset mid-run at run_count 37
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    mode_in = 2'd1;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      tick();
      if (bus_w.run_count == 16'd37) hit = 1'b1;
    end
    check("reach37", hit, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_reset_run", bus_w.core_run, 0);
    check("mid_reset_rst", bus_w.core_reset, 1);
    check("mid_reset_count", bus_w.run_count, 0);
    repeat (3) tick();
    check("mid_stretch", bus_w.core_reset, 1);
    tick();
    check("mid_release", bus_w.core_reset, 0);

    // Random traffic against the model
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin rst_n = 1'b0; tick(); rst_n = 1'b1; end
      else if (r < 5) mode_in = 2'($urandom_range(0, 3));
      else if (r < 7) div_sel = 4'($urandom_range(0, 3));
      else step_in = ~step_in;
      repeat ($urandom_range(1, 24)) begin
        if ($urandom_range(0, 7) == 0) step_in = ~step_in;
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
